dbus_avalon_bridge: RTL and testbench

Parametrised bridge from the VexRiscv simple dBus to NUM_SLAVES Avalon-MM slaves (JTAG UART, timers, future peripherals). It is the generalised successor to the single hard-wired JTAG UART hookup in the top level. The top level decodes the peripheral region and drives this block's cmd_valid. The bridge registers each command, selects one slave by address field, honours waitrequest, returns read data as a single-cycle response, and aborts hung slaves on timeout.

---
 rtl/dbus_avalon_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_dbus_avalon_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_avalon_bridge.sv
// ---------------------------------------------------------------------------
// dbus_avalon_bridge
//
// Bridges the VexRiscv simple dBus to NUM_SLAVES Avalon-MM slaves. One
// command is accepted at a time. Each command is registered, one slave is
// selected by an address field, waitrequest is honoured, and read data comes
// back as a single-cycle response pulse. Writes produce no response.
//
// Optional feature (macro BRIDGE_TIMEOUT_EN): a 16-bit watchdog aborts an
// access whose slave holds waitrequest for TIMEOUT_CYCLES cycles. An aborted
// read returns rsp_error=1 with data 32'hDEAD_BEEF. Without the macro, an
// access waits on waitrequest indefinitely.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   dBus_cmd_*                 command channel (valid/ready, wr, address,
//                              data, size)
//   dBus_rsp_ready/error/data  read response, one-cycle pulse
//   av_chipselect              one-hot slave select
//   av_address/writedata/      shared Avalon request fields
//   av_byteenable
//   av_read_n, av_write_n      active-low strobes
//   av_waitrequest             per-slave waitrequest
//   av_readdata                per-slave read data, slave i at [32i+31:32i]
//   err_flag                   sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------
module dbus_avalon_bridge #(
  parameter int NUM_SLAVES      = 4,
  parameter int SEL_LSB         = 12,
  parameter int SLAVE_ADDR_BITS = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dBus_cmd_valid,
  output logic                       dBus_cmd_ready,
  input  logic                       dBus_cmd_payload_wr,
  input  logic [31:0]                dBus_cmd_payload_address,
  input  logic [31:0]                dBus_cmd_payload_data,
  input  logic [1:0]                 dBus_cmd_payload_size,
  output logic                       dBus_rsp_ready,
  output logic                       dBus_rsp_error,
  output logic [31:0]                dBus_rsp_data,
  output logic [NUM_SLAVES-1:0]      av_chipselect,
  output logic [SLAVE_ADDR_BITS-1:0] av_address,
  output logic                       av_read_n,
  output logic                       av_write_n,
  output logic [31:0]                av_writedata,
  output logic [3:0]                 av_byteenable,
  input  logic [NUM_SLAVES-1:0]      av_waitrequest,
  input  logic [32*NUM_SLAVES-1:0]   av_readdata,
  output logic                       err_flag
);

  localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // The range check looks at a full 4-bit index field (16 slaves maximum),
  // so addresses beyond the populated slaves are caught even when
  // NUM_SLAVES is a power of two and SEL_BITS alone could not express them.
  localparam logic [4:0] NUM_SLAVES_W = 5'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                     state_q, state_d;
  logic                       wr_q, wr_d;
  logic [SEL_BITS-1:0]        idx_q, idx_d;
  logic [SLAVE_ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [3:0]                 be_q, be_d;
  logic [31:0]                rsp_data_q, rsp_data_d;
  logic                       rsp_err_q, rsp_err_d;
  logic                       err_flag_q, err_flag_d;
`ifdef BRIDGE_TIMEOUT_EN
  logic [15:0]                cnt_q, cnt_d;
`endif

  logic [3:0]  raw_idx;
  logic        idx_in_range;
  logic [3:0]  cmd_be;
  logic [31:0] rd_arr [NUM_SLAVES];
  logic        unused_addr;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rd
    assign rd_arr[g] = av_readdata[32*g +: 32];
  end

  assign raw_idx      = dBus_cmd_payload_address[SEL_LSB +: 4];
  assign idx_in_range = ({1'b0, raw_idx} < NUM_SLAVES_W);
  // Only a few address bits are decoded here; the rest are the top level's.
  assign unused_addr  = ^dBus_cmd_payload_address;

  always_comb begin
    case (dBus_cmd_payload_size)
      2'd0:    cmd_be = 4'b0001 << dBus_cmd_payload_address[1:0];
      2'd1:    cmd_be = 4'b0011 << dBus_cmd_payload_address[1:0];
      default: cmd_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_flag_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      err_flag_q <= err_flag_d;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    err_flag_d = err_flag_q;
`ifdef BRIDGE_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (dBus_cmd_valid) begin
          wr_d    = dBus_cmd_payload_wr;
          idx_d   = raw_idx[SEL_BITS-1:0];
          addr_d  = dBus_cmd_payload_address[SLAVE_ADDR_BITS+1:2];
          wdata_d = dBus_cmd_payload_data;
          be_d    = cmd_be;
          if (idx_in_range) begin
            state_d = ACCESS;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // No slave behind this index: reads get an error response,
            // writes are silently dropped.
            err_flag_d = 1'b1;
            if (!dBus_cmd_payload_wr) begin
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
              state_d    = RESP;
            end
          end
        end
      end

      ACCESS: begin
        if (!av_waitrequest[idx_q]) begin
          if (!wr_q) begin
            rsp_data_d = rd_arr[idx_q];
            rsp_err_d  = 1'b0;
            state_d    = RESP;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef BRIDGE_TIMEOUT_EN
        // cnt_q counts completed ACCESS cycles, so the abort lands after
        // exactly TIMEOUT_CYCLES cycles of waitrequest.
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          err_flag_d = 1'b1;
          if (!wr_q) begin
            rsp_data_d = 32'hDEAD_BEEF;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    av_chipselect = '0;
    if (state_q == ACCESS) begin
      av_chipselect[idx_q] = 1'b1;
    end
  end

  // Ready is masked by reset so the command channel is closed while reset
  // is held, even though the state register already reads IDLE.
  assign dBus_cmd_ready = (state_q == IDLE) && !reset;
  assign dBus_rsp_ready = (state_q == RESP);
  assign dBus_rsp_error = (state_q == RESP) && rsp_err_q;
  assign dBus_rsp_data  = rsp_data_q;
  assign av_address     = addr_q;
  assign av_writedata   = wdata_q;
  assign av_byteenable  = be_q;
  assign av_read_n      = !((state_q == ACCESS) && !wr_q);
  assign av_write_n     = !((state_q == ACCESS) && wr_q);
  assign err_flag       = err_flag_q;

endmodule

// File: tb/tb_dbus_avalon_bridge.sv
module tb_dbus_avalon_bridge;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [31:0]   cmd_addr;
  logic [31:0]   cmd_data;
  logic [1:0]    cmd_size;
  logic          rsp_ready;
  logic          rsp_error;
  logic [31:0]   rsp_data;
  logic [NS-1:0] av_cs;
  logic [3:0]    av_addr;
  logic          av_rd_n;
  logic          av_wr_n;
  logic [31:0]   av_wdata;
  logic [3:0]    av_be;
  logic [NS-1:0] av_wait;
  logic [32*NS-1:0] av_rdata;
  logic          err_flag;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dbus_avalon_bridge #(
    .NUM_SLAVES(NS),
    .SEL_LSB(12),
    .SLAVE_ADDR_BITS(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dBus_cmd_valid(cmd_valid),
    .dBus_cmd_ready(cmd_ready),
    .dBus_cmd_payload_wr(cmd_wr),
    .dBus_cmd_payload_address(cmd_addr),
    .dBus_cmd_payload_data(cmd_data),
    .dBus_cmd_payload_size(cmd_size),
    .dBus_rsp_ready(rsp_ready),
    .dBus_rsp_error(rsp_error),
    .dBus_rsp_data(rsp_data),
    .av_chipselect(av_cs),
    .av_address(av_addr),
    .av_read_n(av_rd_n),
    .av_write_n(av_wr_n),
    .av_writedata(av_wdata),
    .av_byteenable(av_be),
    .av_waitrequest(av_wait),
    .av_readdata(av_rdata),
    .err_flag(err_flag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got data=%h err=%b, want no response", rsp_data, rsp_error);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_error !== e.err) begin
          bad++;
          $display("FAIL rsp: got data=%h err=%b, want data=%h err=%b",
                   rsp_data, rsp_error, e.data, e.err);
        end
      end
    end
  end

  // Present one command after a rising edge; it is accepted at the next edge.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_size  = sz;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_size  = 2'd2;
    av_wait   = '0;
    av_rdata  = '0;

    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_cs", av_cs, 4'b0000);
    chk("rst_rd_n", av_rd_n, 1'b1);
    chk("rst_wr_n", av_wr_n, 1'b1);
    chk("rst_be", av_be, 4'h0);
    chk("rst_err_flag", err_flag, 1'b0);
    #10;
    reset = 1'b0;

    // Zero-wait read of slave 1, word address 1
    av_rdata[32 +: 32] = 32'h1234_5678;
    exp_q.push_back('{data: 32'h1234_5678, err: 1'b0});
    send(1'b0, 32'h9000_1004, 32'h0, 2'd2);
    @(negedge clk);
    chk("rd1_cs", av_cs, 4'b0010);
    chk("rd1_addr", av_addr, 4'd1);
    chk("rd1_rd_n", av_rd_n, 1'b0);
    chk("rd1_wr_n", av_wr_n, 1'b1);
    chk("rd1_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    chk("rd1_rsp_pulse", rsp_ready, 1'b1);
    chk("rd1_cs_off", av_cs, 4'b0000);
    chk("rd1_cmd_ready_resp", cmd_ready, 1'b0);
    chk("rd1_err_flag", err_flag, 1'b0);

    // Byte write to slave 2, lane 3
    send(1'b1, 32'h9000_2003, 32'hABAB_ABAB, 2'd0);
    @(negedge clk);
    chk("wr_cs", av_cs, 4'b0100);
    chk("wr_be", av_be, 4'b1000);
    chk("wr_wr_n", av_wr_n, 1'b0);
    chk("wr_rd_n", av_rd_n, 1'b1);
    chk("wr_addr", av_addr, 4'd0);
    chk("wr_wdata", av_wdata, 32'hABAB_ABAB);
    @(negedge clk);
    chk("wr_wr_n_off", av_wr_n, 1'b1);
    chk("wr_cmd_ready_back", cmd_ready, 1'b1);
    chk("wr_no_rsp", rsp_ready, 1'b0);

    // Half-word read at byte offset 2 of slave 0, waitrequest high 5 cycles
    av_rdata[0 +: 32] = 32'hCAFE_F00D;
    av_wait[0] = 1'b1;
    exp_q.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
    send(1'b0, 32'h9000_0008 + 32'd2, 32'h0, 2'd1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) av_wait[0] = 1'b0;
      chk($sformatf("wait_rd_n_c%0d", i), av_rd_n, 1'b0);
      chk($sformatf("wait_cmd_ready_c%0d", i), cmd_ready, 1'b0);
    end
    chk("wait_be", av_be, 4'b1100);
    chk("wait_addr", av_addr, 4'd2);
    @(negedge clk);
    chk("wait_rsp_pulse", rsp_ready, 1'b1);
    @(negedge clk);
    chk("wait_rsp_single", rsp_ready, 1'b0);

    // Read of unpopulated slave index 7
    exp_q.push_back('{data: 32'h0, err: 1'b1});
    send(1'b0, 32'h9000_7000, 32'h0, 2'd2);
    @(negedge clk);
    chk("oor_cs", av_cs, 4'b0000);
    chk("oor_rd_n", av_rd_n, 1'b1);
    chk("oor_err_flag", err_flag, 1'b1);
    chk("oor_rsp_pulse", rsp_ready, 1'b1);

    // Write to unpopulated slave index 5 is dropped
    send(1'b1, 32'h9000_5000, 32'h5555_5555, 2'd2);
    @(negedge clk);
    chk("oorw_cs", av_cs, 4'b0000);
    chk("oorw_wr_n", av_wr_n, 1'b1);
    chk("oorw_cmd_ready", cmd_ready, 1'b1);

    // Slave 2 holds waitrequest on a read
    av_wait[2] = 1'b1;
    av_rdata[64 +: 32] = 32'h7777_2222;
`ifdef BRIDGE_TIMEOUT_EN
    exp_q.push_back('{data: 32'hDEAD_BEEF, err: 1'b1});
    send(1'b0, 32'h9000_2000, 32'h0, 2'd2);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("to_rd_n_c%0d", i), av_rd_n, 1'b0);
    end
    @(negedge clk);
    chk("to_rd_n_off", av_rd_n, 1'b1);
    chk("to_rsp_pulse", rsp_ready, 1'b1);
    chk("to_err_flag", err_flag, 1'b1);
    av_wait[2] = 1'b0;
`else
    exp_q.push_back('{data: 32'h7777_2222, err: 1'b0});
    send(1'b0, 32'h9000_2000, 32'h0, 2'd2);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 20) av_wait[2] = 1'b0;
      chk($sformatf("hold_rd_n_c%0d", i), av_rd_n, 1'b0);
    end
    @(negedge clk);
    chk("hold_rsp_pulse", rsp_ready, 1'b1);
`endif

    // Reset pulsed in the middle of an access to slave 3
    @(negedge clk);
    av_wait[3] = 1'b1;
    av_rdata[96 +: 32] = 32'h0BAD_F00D;
    send(1'b0, 32'h9000_3000, 32'h0, 2'd2);
    @(negedge clk);
    chk("mid_rd_n", av_rd_n, 1'b0);
    chk("mid_cs", av_cs, 4'b1000);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cs", av_cs, 4'b0000);
    chk("arst_rd_n", av_rd_n, 1'b1);
    chk("arst_cmd_ready", cmd_ready, 1'b0);
    chk("arst_err_flag", err_flag, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    av_wait[3] = 1'b0;
    exp_q.push_back('{data: 32'h0BAD_F00D, err: 1'b0});
    send(1'b0, 32'h9000_3000, 32'h0, 2'd2);
    @(negedge clk);
    chk("post_rst_cs", av_cs, 4'b1000);
    @(negedge clk);
    chk("post_rst_rsp_pulse", rsp_ready, 1'b1);

    repeat (3) @(negedge clk);
    chk("pending_rsp_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
